ncc_frame_controller: RTL and testbench

Frame sequencer for the template-matching pipeline (input buffer → template datapath → line-sum accumulators). It accepts image/template lines through a valid/ready handshake, clears the accumulators at frame start, and tracks each accepted line through the fixed-latency pipeline so the accumulators add only real lines. After the last line drains, it presents the accumulated sums as valid until the consumer acknowledges them.

---
 rtl/ncc_frame_controller.sv | 120 ++++++++++++
 tb/tb_ncc_frame_controller.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ncc_frame_controller.sv
// Frame sequencer for the template-matching pipeline: accepts lines,
// tracks them through the fixed-latency datapath and hands off frame sums.
module ncc_frame_controller #(
    parameter int NUM_OF_LINES = 16,
    parameter int PIPE_LAT     = 2,
    parameter int FRAME_CNT_W  = 16
) (
    input  logic                            CLK,
    input  logic                            reset,
    input  logic                            start,
    input  logic                            abort,
    input  logic                            line_valid,
    output logic                            line_ready,
    output logic                            line_fire,
    output logic                            acc_clr,
    output logic                            acc_en,
    output logic                            result_valid,
    input  logic                            result_ack,
    output logic                            done,
    output logic                            busy,
    output logic [$clog2(NUM_OF_LINES)-1:0] line_cnt,
    output logic [FRAME_CNT_W-1:0]          frame_cnt
);

    localparam int LCW = $clog2(NUM_OF_LINES);
    localparam int DW  = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    localparam logic [LCW-1:0] LAST_LINE = LCW'(NUM_OF_LINES - 1);
    localparam logic [DW-1:0]  LAST_DRN  = DW'(PIPE_LAT - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] CLEAR  = 3'd1;
    localparam logic [2:0] STREAM = 3'd2;
    localparam logic [2:0] DRAIN  = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    logic [2:0]             state_q, state_d;
    logic [LCW-1:0]         line_cnt_q, line_cnt_d;
    logic [DW-1:0]          drain_q, drain_d;
    logic [PIPE_LAT-1:0]    pipe_v_q, pipe_v_d;
    logic [FRAME_CNT_W-1:0] frame_q, frame_d;
    logic                   done_q, done_d;

    assign line_ready   = (state_q == STREAM);
    assign line_fire    = line_valid & line_ready;
    assign acc_clr      = (state_q == CLEAR);
    assign acc_en       = pipe_v_q[PIPE_LAT-1];
    assign result_valid = (state_q == DONE);
    assign done         = done_q;
    assign busy         = (state_q != IDLE);
    assign line_cnt     = line_cnt_q;
    assign frame_cnt    = frame_q;

    always_comb begin
        state_d    = state_q;
        line_cnt_d = line_cnt_q;
        drain_d    = drain_q;
        frame_d    = frame_q;
        done_d     = 1'b0;
        // Every accepted line walks the shift register in all states
        pipe_v_d   = (pipe_v_q << 1) | PIPE_LAT'(line_fire);
        if (abort && (state_q != IDLE)) begin
            state_d    = IDLE;
            pipe_v_d   = '0;
            drain_d    = '0;
            line_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) state_d = CLEAR;
                end
                CLEAR: begin
                    line_cnt_d = '0;
                    state_d    = STREAM;
                end
                STREAM: begin
                    if (line_fire) begin
                        if (line_cnt_q == LAST_LINE) state_d = DRAIN;
                        else line_cnt_d = line_cnt_q + LCW'(1);
                    end
                end
                DRAIN: begin
                    if (drain_q == LAST_DRN) begin
                        drain_d = '0;
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        drain_d = drain_q + DW'(1);
                    end
                end
                DONE: begin
                    if (result_ack) begin
                        frame_d = frame_q + FRAME_CNT_W'(1);
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            line_cnt_q <= '0;
            drain_q    <= '0;
            pipe_v_q   <= '0;
            frame_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            line_cnt_q <= line_cnt_d;
            drain_q    <= drain_d;
            pipe_v_q   <= pipe_v_d;
            frame_q    <= frame_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_ncc_frame_controller.sv
// Scoreboard bench for ncc_frame_controller: frame-level timing model,
// queued acc_en/done expectations checked by a negedge monitor.
module tb_ncc_frame_controller;

    localparam int NL = 16;
    localparam int PL = 2;
    localparam int FW = 2;

    logic          CLK = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          line_valid = 1'b0;
    logic          result_ack = 1'b0;
    logic          line_ready, line_fire, acc_clr, acc_en;
    logic          result_valid, done, busy;
    logic [3:0]    line_cnt;
    logic [FW-1:0] frame_cnt;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int fc_model = 0;
    int acc_q[$];
    int done_q[$];

    ncc_frame_controller #(
        .NUM_OF_LINES(NL),
        .PIPE_LAT(PL),
        .FRAME_CNT_W(FW)
    ) dut (
        .CLK(CLK),
        .reset(reset),
        .start(start),
        .abort(abort),
        .line_valid(line_valid),
        .line_ready(line_ready),
        .line_fire(line_fire),
        .acc_clr(acc_clr),
        .acc_en(acc_en),
        .result_valid(result_valid),
        .result_ack(result_ack),
        .done(done),
        .busy(busy),
        .line_cnt(line_cnt),
        .frame_cnt(frame_cnt)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Monitor: every acc_en / done pulse must match the oldest expectation
    always @(negedge CLK) begin
        if (reset) begin
            if (acc_en) begin
                if (acc_q.size() == 0) chk("acc_en_unexpected", 1, 0);
                else chk("acc_en_cycle", cyc, acc_q.pop_front());
            end
            if (done) begin
                if (done_q.size() == 0) chk("done_unexpected", 1, 0);
                else chk("done_cycle", cyc, done_q.pop_front());
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ready"}, line_ready, 0);
        chk({tag, "_fire"}, line_fire, 0);
        chk({tag, "_acc_clr"}, acc_clr, 0);
        chk({tag, "_acc_en"}, acc_en, 0);
        chk({tag, "_rvalid"}, result_valid, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_line_cnt"}, line_cnt, 0);
        chk({tag, "_frame_cnt"}, frame_cnt, 0);
    endtask

    // mode 0: valid always high, 1: low every 3rd STREAM cycle, 2: random
    task automatic frame(input int mode, input int ack_late,
                         input bit do_abort, input bit hold_ack);
        int fires, k, last;
        bit lv;
        tick();
        chk("idle_busy", busy, 0);
        chk("idle_ready", line_ready, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("clear_acc_clr", acc_clr, 1);
        chk("clear_busy", busy, 1);
        chk("clear_ready", line_ready, 0);
        fires = 0;
        k = 0;
        last = 0;
        while (fires < NL && k < 200) begin
            tick();
            chk("stream_ready", line_ready, 1);
            chk("stream_line_cnt", line_cnt, fires);
            if (k == 0) chk("stream_acc_clr_low", acc_clr, 0);
            case (mode)
                0: lv = 1'b1;
                1: lv = (k % 3) != 2;
                default: lv = ($urandom % 4) != 0;
            endcase
            line_valid = lv;
            if (lv) begin
                fires++;
                last = cyc;
                if (!(do_abort && fires == NL)) acc_q.push_back(cyc + PL);
            end
            k++;
        end
        if (k >= 200) chk("stream_budget", k, 0);
        tick();
        line_valid = 1'($urandom % 2);
        chk("drain_ready", line_ready, 0);
        chk("drain_line_cnt", line_cnt, NL - 1);
        chk("drain_busy", busy, 1);
        if (do_abort) begin
            abort = 1'b1;
            tick();
            abort = 1'b0;
            line_valid = 1'b0;
            chk("abort_busy", busy, 0);
            chk("abort_rvalid", result_valid, 0);
            chk("abort_line_cnt", line_cnt, 0);
            chk("abort_frame_cnt", frame_cnt, fc_model);
            repeat (6) tick();
            chk("abort_later_busy", busy, 0);
            chk("abort_later_rvalid", result_valid, 0);
            return;
        end
        done_q.push_back(last + PL + 1);
        while (cyc < last + PL + 1) tick();
        line_valid = 1'b0;
        chk("done_rvalid", result_valid, 1);
        chk("done_pulse", done, 1);
        chk("done_acc_drained", acc_q.size(), 0);
        for (int j = 0; j < ack_late; j++) begin
            start = 1'($urandom % 2);
            line_valid = 1'($urandom % 2);
            tick();
            chk("wait_rvalid", result_valid, 1);
            chk("wait_done_low", done, 0);
            chk("wait_frame_cnt", frame_cnt, fc_model);
        end
        start = 1'b0;
        line_valid = 1'b0;
        result_ack = 1'b1;
        tick();
        fc_model = (fc_model + 1) % (1 << FW);
        chk("ack_busy", busy, 0);
        chk("ack_rvalid", result_valid, 0);
        chk("ack_frame_cnt", frame_cnt, fc_model);
        if (hold_ack) begin
            repeat (3) begin
                tick();
                chk("idle_ack_frame_cnt", frame_cnt, fc_model);
            end
        end
        result_ack = 1'b0;
    endtask

    task automatic reset_mid();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            line_valid = 1'b1;
            acc_q.push_back(cyc + PL);
        end
        tick();
        chk("pre_reset_line_cnt", line_cnt, 7);
        #2;
        reset = 1'b0;
        #1;
        acc_q.delete();
        line_valid = 1'b0;
        fc_model = 0;
        check_all_zero("async_rst");
        repeat (3) tick();
        #2;
        reset = 1'b1;
    endtask

    initial begin
        #1;
        check_all_zero("reset");
        tick();
        reset = 1'b1;
        frame(0, 2, 1'b0, 1'b0);
        frame(1, 0, 1'b0, 1'b0);
        frame(0, 0, 1'b1, 1'b0);
        frame(0, 5, 1'b0, 1'b1);
        frame(2, 1, 1'b0, 1'b0);
        frame(0, 0, 1'b0, 1'b0);
        reset_mid();
        frame(2, 3, 1'b0, 1'b0);
        repeat (4) tick();
        chk("end_acc_queue_empty", acc_q.size(), 0);
        chk("end_done_queue_empty", done_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
